// File: rtl/hilo_div_pkg.sv
// hilo_div_pkg: shared divider state encodings and ready constants used by the execute stage.
package hilo_div_pkg;
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;
  localparam int DIV_ITER = 32;
  localparam logic DIV_RESULT_READY = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
endpackage

// File: rtl/hilo_div_step.sv
// div_step: one restoring-division iteration on the {remainder, quotient} register.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] din,
  input  logic [WIDTH-1:0] divisor,
  output logic [2*WIDTH:0] dout
);
  logic [2*WIDTH:0] s;
  logic [WIDTH:0] trial;
  always_comb begin
    s = din << 1;
    trial = s[2*WIDTH:WIDTH] - {1'b0, divisor};
    dout = trial[WIDTH] ? s : {trial, s[WIDTH-1:1], 1'b1};
  end
endmodule

// File: rtl/hilo_div.sv
// hilo_div: multi-cycle signed/unsigned restoring divider answering execute-stage requests.
module hilo_div
  import hilo_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER = WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               start,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
);
  localparam int CW = $clog2(ITER) + 1;
  div_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2*WIDTH:0] dividend, step;
  logic [WIDTH-1:0] divisor, mag1, mag2, quot, rem, q_fix, r_fix;
  logic neg1, neg2, accept, finish;
  div_step #(.WIDTH(WIDTH)) u_step (.din(dividend), .divisor(divisor), .dout(step));
  assign accept = state == DIV_FREE && start && !annul;
  assign finish = state == DIV_ON && !annul && cnt == CW'(ITER);
  assign mag1 = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
  assign mag2 = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
  assign quot = dividend[WIDTH-1:0];
  assign rem = dividend[2*WIDTH-1:WIDTH];
  assign q_fix = (neg1 ^ neg2) ? -quot : quot;
  assign r_fix = neg1 ? -rem : rem;
  always_comb begin
    state_n = state;
    case (state)
      DIV_FREE:    state_n = accept ? (opdata2 == '0 ? DIV_BY_ZERO : DIV_ON) : DIV_FREE;
      // divide-by-zero answers on the second edge spent here
      DIV_BY_ZERO: state_n = annul ? DIV_FREE : (cnt == CW'(1) ? DIV_END : DIV_BY_ZERO);
      DIV_ON:      state_n = annul ? DIV_FREE : (finish ? DIV_END : DIV_ON);
      DIV_END:     state_n = start ? DIV_END : DIV_FREE;
      default:     state_n = DIV_FREE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= DIV_FREE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      dividend <= '0;
      divisor <= '0;
      neg1 <= 1'b0;
      neg2 <= 1'b0;
      result <= '0;
      ready <= DIV_RESULT_NOT_READY;
    end else begin
      ready <= state_n == DIV_END ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
      result <= finish ? {r_fix, q_fix} : (state == DIV_END && start) ? result : '0;
      if (accept) begin
        neg1 <= signed_div & opdata1[WIDTH-1];
        neg2 <= signed_div & opdata2[WIDTH-1];
        dividend <= {(WIDTH+1)'(0), mag1};
        divisor <= mag2;
        cnt <= '0;
      end else if (state == DIV_ON || state == DIV_BY_ZERO) begin
        cnt <= cnt + 1'b1;
        if (state == DIV_ON && !finish) dividend <= step;
      end
    end
  end
endmodule

// File: tb/tb_hilo_div.sv
// tb_hilo_div: directed checks of hilo_div latency, results, annul and reset behaviour.
module tb_hilo_div;
  logic clk, reset, signed_div, start, annul, ready;
  logic [31:0] opdata1, opdata2;
  logic [63:0] result;
  int total = 0;
  int bad = 0;
  hilo_div dut (
    .clk(clk), .reset(reset), .signed_div(signed_div), .opdata1(opdata1),
    .opdata2(opdata2), .start(start), .annul(annul), .result(result), .ready(ready)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run(string tag, logic [31:0] a, logic [31:0] b, logic sg,
                     logic [63:0] exp, int lat, bit scr);
    opdata1 = a;
    opdata2 = b;
    signed_div = sg;
    start = 1'b1;
    tick();
    if (scr) begin
      opdata1 = 32'd1;
      opdata2 = 32'd1;
      signed_div = ~sg;
    end
    repeat (lat - 1) tick();
    chk({tag, "_early"}, {63'b0, ready}, 64'd0);
    tick();
    chk({tag, "_ready"}, {63'b0, ready}, 64'd1);
    chk({tag, "_result"}, result, exp);
    tick();
    chk({tag, "_hold"}, {ready, result}, {1'b1, exp});
    start = 1'b0;
    tick();
    chk({tag, "_drop"}, {ready, result}, 65'd0);
    tick();
  endtask
  initial begin
    bit seen;
    reset = 1'b1;
    start = 1'b0;
    annul = 1'b0;
    signed_div = 1'b0;
    opdata1 = '0;
    opdata2 = '0;
    tick();
    chk("reset", {ready, result}, 65'd0);
    reset = 1'b0;
    tick();
    run("u100_7", 32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 33, 1'b0);
    run("s_m7_2", 32'hFFFFFFF9, 32'h2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1'b0);
    run("s_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, 33, 1'b0);
    run("u_max_1", 32'hFFFFFFFF, 32'h1, 1'b0, {32'h0, 32'hFFFFFFFF}, 33, 1'b0);
    run("u_big_div", 32'hFFFFFFFF, 32'h80000001, 1'b0, {32'h7FFFFFFE, 32'h1}, 33, 1'b0);
    run("div0", 32'd5, 32'd0, 1'b0, 64'd0, 2, 1'b0);
    run("s_0_m1", 32'd0, 32'hFFFFFFFF, 1'b1, 64'd0, 33, 1'b0);
    opdata1 = 32'd100;
    opdata2 = 32'd7;
    signed_div = 1'b0;
    start = 1'b1;
    tick();
    repeat (10) tick();
    annul = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      tick();
      seen |= ready;
    end
    chk("annul_no_ready", {63'b0, seen}, 64'd0);
    chk("annul_result", result, 64'd0);
    start = 1'b0;
    annul = 1'b0;
    tick();
    run("after_annul", 32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, 33, 1'b0);
    run("scramble", 32'd50, 32'd6, 1'b0, {32'h2, 32'h8}, 33, 1'b1);
    opdata1 = 32'd100;
    opdata2 = 32'd7;
    start = 1'b1;
    repeat (34) tick();
    chk("pre_reset_ready", {63'b0, ready}, 64'd1);
    #2 reset = 1'b1;
    #1 chk("async_reset_end", {ready, result}, 65'd0);
    start = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    start = 1'b1;
    repeat (6) tick();
    #2 reset = 1'b1;
    #1 chk("async_reset_on", {ready, result}, 65'd0);
    start = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    run("after_reset", 32'd64, 32'd8, 1'b0, {32'h0, 32'h8}, 33, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
